parity_frame_rx: RTL and testbench

Serial receiver directly upstream of the parity checker. It deserializes a 7-bit asynchronous frame from a single serial line and presents the four data bits and the received parity bit, registered and held, to the checker's `a,b,c,d,p` inputs. It strobes `valid` once per good frame and `ferr` on a framing error. It does not evaluate parity itself; that is the checker's job.

---
 rtl/parity_rx_pkg.sv | 14 +
 rtl/sync2.sv | 21 ++
 rtl/parity_frame_rx.sv | 142 ++++++++++++++
 tb/tb_parity_frame_rx.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_rx_pkg.sv
// rtl/parity_rx_pkg.sv - shared types and constants for the parity frame receiver
package parity_rx_pkg;

    localparam int DEF_BIT_CYCLES = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - two-flop synchronizer for an asynchronous line that idles high
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b1;
            q  <= 1'b1;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/parity_frame_rx.sv
// rtl/parity_frame_rx.sv - deserializes a start/4 data/parity/stop frame for the parity checker
module parity_frame_rx
    import parity_rx_pkg::*;
#(
    parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic sin,
    output logic a,
    output logic b,
    output logic c,
    output logic d,
    output logic p,
    output logic valid,
    output logic ferr,
    output logic busy
);

    localparam int CW = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BIT_CYCLES / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BIT_CYCLES - 1);

    logic ss;

    rx_state_t     state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    idx, idx_n;
    logic [3:0]    shd, shd_n;
    logic          shp, shp_n;
    logic [3:0]    dat_q, dat_n;
    logic          par_q, par_n;
    logic          valid_n, ferr_n;

    sync2 u_sync (
        .clk (clk),
        .rst (rst),
        .d   (sin),
        .q   (ss)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shd   <= '0;
            shp   <= 1'b0;
            dat_q <= '0;
            par_q <= 1'b0;
            valid <= 1'b0;
            ferr  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shd   <= shd_n;
            shp   <= shp_n;
            dat_q <= dat_n;
            par_q <= par_n;
            valid <= valid_n;
            ferr  <= ferr_n;
        end
    end

    // Every sampling state counts down to zero, samples mid-bit, then reloads.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shd_n   = shd;
        shp_n   = shp;
        dat_n   = dat_q;
        par_n   = par_q;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                if (!ss) begin
                    state_n = START;
                    cnt_n   = HALF_LOAD;
                end
            end
            START: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (!ss) begin
                    state_n = DATA;
                    idx_n   = 2'd0;
                    cnt_n   = FULL_LOAD;
                end else begin
                    state_n = IDLE;
                end
            end
            DATA: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    shd_n[idx] = ss;
                    cnt_n      = FULL_LOAD;
                    if (idx == 2'd3) begin
                        state_n = PARITY;
                    end else begin
                        idx_n = idx + 2'd1;
                    end
                end
            end
            PARITY: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    shp_n   = ss;
                    cnt_n   = FULL_LOAD;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    if (ss) begin
                        dat_n   = shd;
                        par_n   = shp;
                        valid_n = 1'b1;
                    end else begin
                        ferr_n = 1'b1;
                    end
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign a    = dat_q[0];
    assign b    = dat_q[1];
    assign c    = dat_q[2];
    assign d    = dat_q[3];
    assign p    = par_q;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_parity_frame_rx.sv
// tb/tb_parity_frame_rx.sv - self-checking bench for parity_frame_rx
module tb_parity_frame_rx;

    localparam int B   = 4;
    localparam int H   = B / 2;
    localparam int LAT = 2 + H + 6 * B;

    logic clk = 1'b0;
    logic rst, sin;
    logic a, b, c, d, p, valid, ferr, busy;

    parity_frame_rx #(.BIT_CYCLES(B)) dut (
        .clk   (clk),
        .rst   (rst),
        .sin   (sin),
        .a     (a),
        .b     (b),
        .c     (c),
        .d     (d),
        .p     (p),
        .valid (valid),
        .ferr  (ferr),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         eno;
        int         kind;
        logic [4:0] bits;
    } ev_t;

    ev_t evq[$];
    int  edge_no   = 0;
    int  busy_cnt  = 0;
    int  both_cnt  = 0;
    int  pass_cnt  = 0;
    int  total_cnt = 0;

    always @(posedge clk) edge_no++;

    always @(negedge clk) begin
        ev_t e;
        if (valid || ferr) begin
            e.eno  = edge_no;
            e.kind = valid ? 1 : 2;
            e.bits = {a, b, c, d, p};
            evq.push_back(e);
        end
        if (valid && ferr) both_cnt++;
        if (busy) busy_cnt++;
    end

    function automatic logic [6:0] mk_frame(input logic [3:0] abcd, input logic par, input logic stop);
        return {stop, par, abcd[0], abcd[1], abcd[2], abcd[3], 1'b0};
    endfunction

    task automatic send_slots(input logic [6:0] f, input int nslots, output int fall);
        @(posedge clk);
        #1;
        fall = edge_no + 1;
        for (int i = 0; i < nslots; i++) begin
            sin = f[i];
            repeat (B) @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        sin = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        sin = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({a, b, c, d, p, valid, ferr, busy} !== 8'h00)
            $display("FAIL reset_outputs: got %b expected 00000000", {a, b, c, d, p, valid, ferr, busy});
        else pass_cnt++;
        rst = 1'b0;
        evq.delete();
        busy_cnt = 0;
        idle(50);
        total_cnt++;
        if (evq.size() != 0) $display("FAIL idle_pulses: got %0d expected 0", evq.size());
        else pass_cnt++;
        total_cnt++;
        if (busy_cnt != 0) $display("FAIL idle_busy: got %0d expected 0", busy_cnt);
        else pass_cnt++;
        total_cnt++;
        if ({a, b, c, d, p} !== 5'b0) $display("FAIL idle_data: got %b expected 00000", {a, b, c, d, p});
        else pass_cnt++;
    endtask

    task automatic test_good_frame(input string nm, input logic [3:0] abcd, input logic par);
        int fall;
        evq.delete();
        send_slots(mk_frame(abcd, par, 1'b1), 7, fall);
        idle(10);
        total_cnt++;
        if (evq.size() != 1 || evq[0].kind != 1) begin
            $display("FAIL %s_pulse: got %0d events expected one valid", nm, evq.size());
        end else begin
            pass_cnt++;
            total_cnt++;
            if (evq[0].eno != fall + LAT)
                $display("FAIL %s_latency: got edge %0d expected %0d", nm, evq[0].eno - fall, LAT);
            else pass_cnt++;
            total_cnt++;
            if (evq[0].bits !== {abcd, par})
                $display("FAIL %s_bits: got %b expected %b", nm, evq[0].bits, {abcd, par});
            else pass_cnt++;
            total_cnt++;
            if ((^evq[0].bits) !== (^abcd ^ par))
                $display("FAIL %s_checker: got %b expected %b", nm, ^evq[0].bits, ^abcd ^ par);
            else pass_cnt++;
        end
    endtask

    task automatic test_framing_error;
        int fall;
        logic [4:0] prev;
        prev = {a, b, c, d, p};
        evq.delete();
        send_slots(mk_frame(4'($urandom), 1'($urandom), 1'b0), 7, fall);
        idle(10);
        total_cnt++;
        if (evq.size() != 1 || evq[0].kind != 2) begin
            $display("FAIL ferr_pulse: got %0d events expected one ferr", evq.size());
        end else begin
            pass_cnt++;
            total_cnt++;
            if (evq[0].eno != fall + LAT)
                $display("FAIL ferr_latency: got edge %0d expected %0d", evq[0].eno - fall, LAT);
            else pass_cnt++;
        end
        total_cnt++;
        if ({a, b, c, d, p} !== prev) $display("FAIL ferr_hold: got %b expected %b", {a, b, c, d, p}, prev);
        else pass_cnt++;
    endtask

    task automatic test_glitch;
        evq.delete();
        busy_cnt = 0;
        @(posedge clk);
        #1;
        sin = 1'b0;
        @(posedge clk);
        #1;
        idle(20);
        total_cnt++;
        if (evq.size() != 0) $display("FAIL glitch_pulses: got %0d expected 0", evq.size());
        else pass_cnt++;
        total_cnt++;
        if (busy_cnt != H) $display("FAIL glitch_busy: got %0d expected %0d", busy_cnt, H);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_data;
        int fall;
        evq.delete();
        send_slots(mk_frame(4'($urandom), 1'($urandom), 1'b1), 4, fall);
        rst = 1'b1;
        sin = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(30);
        total_cnt++;
        if (evq.size() != 0) $display("FAIL abort_pulses: got %0d expected 0", evq.size());
        else pass_cnt++;
        total_cnt++;
        if ({a, b, c, d, p, busy} !== 6'b0) $display("FAIL abort_state: got %b expected 000000", {a, b, c, d, p, busy});
        else pass_cnt++;
        test_good_frame("after_abort", 4'b0110, 1'b0);
    endtask

    task automatic test_reset_at_stop;
        int fall;
        evq.delete();
        send_slots(mk_frame(4'($urandom), 1'($urandom), 1'b1), 7, fall);
        rst = 1'b1;
        sin = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(10);
        total_cnt++;
        if (evq.size() != 0) $display("FAIL rst_at_stop_pulses: got %0d expected 0", evq.size());
        else pass_cnt++;
        total_cnt++;
        if ({a, b, c, d, p} !== 5'b0) $display("FAIL rst_at_stop_data: got %b expected 00000", {a, b, c, d, p});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back;
        int         falls[8];
        logic [4:0] exp_bits[8];
        evq.delete();
        for (int i = 0; i < 8; i++) begin
            logic [3:0] abcd;
            logic       par;
            abcd = 4'($urandom);
            par  = (^abcd) ^ ($urandom_range(0, 3) == 0);
            exp_bits[i] = {abcd, par};
            send_slots(mk_frame(abcd, par, 1'b1), 7, falls[i]);
        end
        idle(20);
        total_cnt++;
        if (evq.size() != 8) $display("FAIL b2b_count: got %0d expected 8", evq.size());
        else pass_cnt++;
        for (int i = 0; i < 8 && i < evq.size(); i++) begin
            total_cnt++;
            if (evq[i].kind != 1 || evq[i].eno != falls[i] + LAT || evq[i].bits !== exp_bits[i])
                $display("FAIL b2b_frame%0d: got kind %0d edge %0d bits %b expected kind 1 edge %0d bits %b",
                         i, evq[i].kind, evq[i].eno - falls[i], evq[i].bits, LAT, exp_bits[i]);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst = 1'b1;
        sin = 1'b1;
        test_reset;
        test_good_frame("good", 4'b1011, 1'b1);
        test_good_frame("parity_err", 4'b1100, 1'b1);
        test_framing_error;
        test_glitch;
        test_reset_mid_data;
        test_reset_at_stop;
        test_back_to_back;
        total_cnt++;
        if (both_cnt != 0) $display("FAIL valid_ferr_overlap: got %0d expected 0", both_cnt);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
